// File: rtl/r5fp_div_issue_q.sv
// r5fp_div_issue_q: tagged request FIFO and single-outstanding issue sequencer in front of the R5FP divider.
// Define R5FP_DIV_ISSUE_TIMEOUT_EN to add a WAIT-state watchdog that returns a quiet NaN on expiry.
module r5fp_div_issue_q #(
    parameter int SIG_W   = 23,
    parameter int EXP_W   = 8,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [SIG_W+EXP_W:0]     req_a_i,
    input  logic [SIG_W+EXP_W:0]     req_b_i,
    input  logic [2:0]               req_rnd_i,
    input  logic [TAG_W-1:0]         req_tag_i,
    output logic [SIG_W+EXP_W:0]     div_a_o,
    output logic [SIG_W+EXP_W:0]     div_b_o,
    output logic [2:0]               div_rnd_o,
    output logic                     div_strobe_o,
    input  logic                     div_ready_i,
    input  logic                     div_done_i,
    input  logic [SIG_W+EXP_W:0]     div_z_i,
    input  logic [7:0]               div_status_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [SIG_W+EXP_W:0]     rsp_z_o,
    output logic [7:0]               rsp_status_o,
    output logic [TAG_W-1:0]         rsp_tag_o,
    output logic                     busy_o,
    output logic                     timeout_o
);
    localparam int W     = SIG_W + EXP_W + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic [2:0]       rnd;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef enum logic {IDLE, WAIT} state_t;

    req_t             fifo_q [DEPTH];
    req_t             fifo_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic [W-1:0]     div_a_q, div_a_d, div_b_q, div_b_d;
    logic [2:0]       div_rnd_q, div_rnd_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             div_strobe_q, div_strobe_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [W-1:0]     rsp_z_q, rsp_z_d;
    logic [7:0]       rsp_status_q, rsp_status_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic             timeout_q, timeout_d;
    logic             push, issue, expire;

`ifdef R5FP_DIV_ISSUE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Expires on the last edge of WAIT cycle TIMEOUT; a coincident done takes priority.
    assign expire = (state_q == WAIT) & ~div_done_i & (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (issue) begin
            tmo_cnt_d = '0;
        end else if (state_q == WAIT) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    assign req_ready_o  = (count_q != CNT_W'(DEPTH));
    assign div_a_o      = div_a_q;
    assign div_b_o      = div_b_q;
    assign div_rnd_o    = div_rnd_q;
    assign div_strobe_o = div_strobe_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_z_o      = rsp_z_q;
    assign rsp_status_o = rsp_status_q;
    assign rsp_tag_o    = rsp_tag_q;
    assign timeout_o    = timeout_q;
    assign busy_o       = (count_q != '0) | (state_q != IDLE) | rsp_valid_q;

    always_comb begin
        push  = req_valid_i & req_ready_o;
        // Only issue when the response slot is empty, so at most one result is ever in flight.
        issue = (state_q == IDLE) & (count_q != '0) & div_ready_i & ~rsp_valid_q;

        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        state_d      = state_q;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        div_rnd_d    = div_rnd_q;
        tag_d        = tag_q;
        div_strobe_d = issue;
        rsp_valid_d  = rsp_valid_q;
        rsp_z_d      = rsp_z_q;
        rsp_status_d = rsp_status_q;
        rsp_tag_d    = rsp_tag_q;
        timeout_d    = expire;

        if (push) begin
            fifo_d[wr_ptr_q] = '{a: req_a_i, b: req_b_i, rnd: req_rnd_i, tag: req_tag_i};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        case ({push, issue})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (rsp_valid_q & rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (issue) begin
                    rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                    div_a_d   = fifo_q[rd_ptr_q].a;
                    div_b_d   = fifo_q[rd_ptr_q].b;
                    div_rnd_d = fifo_q[rd_ptr_q].rnd;
                    tag_d     = fifo_q[rd_ptr_q].tag;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (div_done_i) begin
                    state_d      = IDLE;
                    rsp_valid_d  = 1'b1;
                    rsp_z_d      = div_z_i;
                    rsp_status_d = div_status_i;
                    rsp_tag_d    = tag_q;
                end else if (expire) begin
                    state_d      = IDLE;
                    rsp_valid_d  = 1'b1;
                    rsp_z_d      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(SIG_W-1){1'b0}}};
                    rsp_status_d = 8'h00;
                    rsp_tag_d    = tag_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            div_a_q      <= '0;
            div_b_q      <= '0;
            div_rnd_q    <= '0;
            tag_q        <= '0;
            div_strobe_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_z_q      <= '0;
            rsp_status_q <= '0;
            rsp_tag_q    <= '0;
            timeout_q    <= 1'b0;
        end else begin
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            div_rnd_q    <= div_rnd_d;
            tag_q        <= tag_d;
            div_strobe_q <= div_strobe_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_z_q      <= rsp_z_d;
            rsp_status_q <= rsp_status_d;
            rsp_tag_q    <= rsp_tag_d;
            timeout_q    <= timeout_d;
        end
    end

endmodule
